// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port SRAM arbiter: FSM states,
// port indices, the latched access record and the registered pad bundle.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    STROBE = 2'd2,
    DONE   = 2'd3
  } arb_state_t;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_DMA = 1'b1;

  localparam int ADDR_W = 20;
  localparam int DATA_W = 16;

  // Everything captured from the granted port at grant time.
  typedef struct packed {
    logic              idx;
    logic              we;
    logic [1:0]        be;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } access_t;

  // All SRAM-side and ack outputs, registered together as one bundle.
  typedef struct packed {
    logic              ce;
    logic              ub;
    logic              lb;
    logic              oe;
    logic              we;
    logic              data_oe;
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] data_out;
    logic              ack0;
    logic              ack1;
  } pads_t;

  // Bus parked: strobes inactive, pad released, address zeroed.
  function automatic pads_t idle_pads(input logic [DATA_W-1:0] data_out);
    pads_t p;
    p.ce       = 1'b1;
    p.ub       = 1'b1;
    p.lb       = 1'b1;
    p.oe       = 1'b1;
    p.we       = 1'b1;
    p.data_oe  = 1'b0;
    p.a        = '0;
    p.data_out = data_out;
    p.ack0     = 1'b0;
    p.ack1     = 1'b0;
    return p;
  endfunction

endpackage

// File: rtl/mem_arb_rr.sv
// Two-way round-robin grant: a lone requester always wins, a tie goes to
// the port that was not granted last.
module mem_arb_rr (
  input  logic req0,
  input  logic req1,
  input  logic last_grant,
  output logic gnt_valid,
  output logic gnt_idx
);
  import mem_arb_pkg::*;

  always_comb begin
    gnt_valid = req0 | req1;
    gnt_idx   = PORT_CPU;
    if (req0 && req1) begin
      gnt_idx = ~last_grant;
    end else if (req1) begin
      gnt_idx = PORT_DMA;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port arbiter in front of an asynchronous 16-bit SRAM. Each access runs
// IDLE -> SETUP -> STROBE (WAIT_CYCLES+1) -> DONE; all pad outputs are flops.
module mem_arbiter #(
  parameter int WAIT_CYCLES = 1
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        req0,
  input  logic        req1,
  input  logic        we0,
  input  logic        we1,
  input  logic [1:0]  be0,
  input  logic [1:0]  be1,
  input  logic [19:0] addr0,
  input  logic [19:0] addr1,
  input  logic [15:0] wdata0,
  input  logic [15:0] wdata1,
  output logic        ack0,
  output logic        ack1,
  output logic [15:0] rdata,
  output logic        CE,
  output logic        UB,
  output logic        LB,
  output logic        OE,
  output logic        WE,
  output logic [19:0] A,
  output logic [15:0] Data_out,
  output logic        Data_oe,
  input  logic [15:0] Data_in
);
  import mem_arb_pkg::*;

  localparam logic [2:0] WAIT_LOAD = WAIT_CYCLES[2:0];

  arb_state_t  r_state, w_state_next;
  logic [2:0]  r_wait_cnt, w_wait_cnt_next;
  access_t     r_acc, w_acc_next;
  logic        r_last_grant, w_last_grant_next;
  logic [15:0] r_rdata, w_rdata_next;
  pads_t       r_pads, w_pads_next;
  logic        w_gnt_valid;
  logic        w_gnt_idx;

  mem_arb_rr u_rr (
    .req0       (req0),
    .req1       (req1),
    .last_grant (r_last_grant),
    .gnt_valid  (w_gnt_valid),
    .gnt_idx    (w_gnt_idx)
  );

  always_comb begin : next_state
    w_state_next      = r_state;
    w_wait_cnt_next   = r_wait_cnt;
    w_acc_next        = r_acc;
    w_last_grant_next = r_last_grant;
    w_rdata_next      = r_rdata;
    unique case (r_state)
      IDLE: begin
        if (w_gnt_valid) begin
          w_state_next      = SETUP;
          w_last_grant_next = w_gnt_idx;
          w_acc_next.idx    = w_gnt_idx;
          if (w_gnt_idx == PORT_DMA) begin
            w_acc_next.we    = we1;
            w_acc_next.be    = be1;
            w_acc_next.addr  = addr1;
            w_acc_next.wdata = wdata1;
          end else begin
            w_acc_next.we    = we0;
            w_acc_next.be    = be0;
            w_acc_next.addr  = addr0;
            w_acc_next.wdata = wdata0;
          end
        end
      end
      SETUP: begin
        w_state_next    = STROBE;
        w_wait_cnt_next = WAIT_LOAD;
      end
      STROBE: begin
        if (r_wait_cnt == 3'd0) begin
          w_state_next = DONE;
          if (!r_acc.we) begin
            w_rdata_next = Data_in;
          end
        end else begin
          w_wait_cnt_next = r_wait_cnt - 3'd1;
        end
      end
      DONE: begin
        w_state_next = IDLE;
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  // Pads are decoded from the upcoming state so the flops line up with it.
  always_comb begin : pad_next
    w_pads_next = idle_pads(w_acc_next.wdata);
    unique case (w_state_next)
      SETUP, STROBE: begin
        w_pads_next.ce = 1'b0;
        w_pads_next.a  = w_acc_next.addr;
        w_pads_next.ub = ~w_acc_next.be[1];
        w_pads_next.lb = ~w_acc_next.be[0];
        if (w_acc_next.we) begin
          w_pads_next.data_oe = 1'b1;
          w_pads_next.we      = (w_state_next != STROBE);
        end else begin
          w_pads_next.oe = 1'b0;
        end
      end
      DONE: begin
        // Keep driving write data one extra cycle for SRAM data hold.
        w_pads_next.data_oe = w_acc_next.we;
        w_pads_next.ack0    = (w_acc_next.idx == PORT_CPU);
        w_pads_next.ack1    = (w_acc_next.idx == PORT_DMA);
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state      <= IDLE;
      r_wait_cnt   <= 3'd0;
      r_acc        <= '0;
      r_last_grant <= PORT_DMA;
      r_rdata      <= 16'h0000;
      r_pads       <= idle_pads(16'h0000);
    end else begin
      r_state      <= w_state_next;
      r_wait_cnt   <= w_wait_cnt_next;
      r_acc        <= w_acc_next;
      r_last_grant <= w_last_grant_next;
      r_rdata      <= w_rdata_next;
      r_pads       <= w_pads_next;
    end
  end

  assign ack0     = r_pads.ack0;
  assign ack1     = r_pads.ack1;
  assign rdata    = r_rdata;
  assign CE       = r_pads.ce;
  assign UB       = r_pads.ub;
  assign LB       = r_pads.lb;
  assign OE       = r_pads.oe;
  assign WE       = r_pads.we;
  assign A        = r_pads.a;
  assign Data_out = r_pads.data_out;
  assign Data_oe  = r_pads.data_oe;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: three instances (WAIT_CYCLES 1, 0, 3), each with a
// small SRAM model; directed vector table, hand sequences, random run.
module tb_mem_arbiter;

  logic clk = 1'b0;
  initial forever #5 clk = ~clk;

  logic [2:0]       rst, req0, req1, we0, we1, ack0, ack1;
  logic [2:0]       ce, ub, lb, oe, we_n, doe;
  logic [2:0][1:0]  be0, be1;
  logic [2:0][19:0] addr0, addr1, a;
  logic [2:0][15:0] wd0, wd1, rdata, dout, din;

  for (genvar gi = 0; gi < 3; gi++) begin : g_dut
    localparam int W = (gi == 0) ? 1 : ((gi == 1) ? 0 : 3);
    logic [15:0] mem [256];

    mem_arbiter #(.WAIT_CYCLES(W)) u_dut (
      .Clk(clk), .Reset(rst[gi]),
      .req0(req0[gi]), .req1(req1[gi]), .we0(we0[gi]), .we1(we1[gi]),
      .be0(be0[gi]), .be1(be1[gi]), .addr0(addr0[gi]), .addr1(addr1[gi]),
      .wdata0(wd0[gi]), .wdata1(wd1[gi]),
      .ack0(ack0[gi]), .ack1(ack1[gi]), .rdata(rdata[gi]),
      .CE(ce[gi]), .UB(ub[gi]), .LB(lb[gi]), .OE(oe[gi]), .WE(we_n[gi]),
      .A(a[gi]), .Data_out(dout[gi]), .Data_oe(doe[gi]), .Data_in(din[gi])
    );

    initial for (int i = 0; i < 256; i++) mem[i] = 16'h0000;

    always @(posedge clk) begin
      if (!ce[gi] && !we_n[gi]) begin
        if (!lb[gi]) mem[a[gi][7:0]][7:0]  = dout[gi][7:0];
        if (!ub[gi]) mem[a[gi][7:0]][15:8] = dout[gi][15:8];
      end
    end

    assign din[gi] = (!ce[gi] && !oe[gi]) ? mem[a[gi][7:0]] : 16'hDEAD;
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic drive(input int inst, input int port, input logic rq, input logic w,
                       input logic [1:0] be, input logic [19:0] ad, input logic [15:0] wd);
    if (port == 0) begin
      req0[inst] = rq; we0[inst] = w; be0[inst] = be; addr0[inst] = ad; wd0[inst] = wd;
    end else begin
      req1[inst] = rq; we1[inst] = w; be1[inst] = be; addr1[inst] = ad; wd1[inst] = wd;
    end
  endtask

  // Observations from one directed access
  int          o_lat, o_welow, o_oelow;
  logic        o_port, o_ub1, o_lb1, o_doe;
  logic [19:0] o_a1;
  logic [15:0] o_rd, o_dout;

  task automatic do_access(input int inst, input int port, input logic w, input logic [1:0] be,
                           input logic [19:0] ad, input logic [15:0] wd);
    drive(inst, port, 1'b1, w, be, ad, wd);
    o_lat = 99; o_welow = 0; o_oelow = 0; o_port = 1'b0;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (!we_n[inst]) o_welow++;
      if (!oe[inst]) o_oelow++;
      if (n == 1) begin
        o_ub1 = ub[inst]; o_lb1 = lb[inst]; o_a1 = a[inst];
      end
      if (ack0[inst] || ack1[inst]) begin
        o_lat = n; o_port = ack1[inst]; o_rd = rdata[inst];
        o_dout = dout[inst]; o_doe = doe[inst];
        break;
      end
    end
    drive(inst, port, 1'b0, 1'b0, 2'b00, 20'h0, 16'h0);
    @(negedge clk);
  endtask

  typedef struct {
    int          inst;
    int          port;
    logic        we;
    logic [1:0]  be;
    logic [19:0] addr;
    logic [15:0] wd;
    int          lat;
    int          welow;
    int          oelow;
    logic        ub;
    logic        lb;
    logic [15:0] rd;
  } vec_t;

  vec_t vt [10];

  // Random-phase reference state
  logic [15:0] mdl [256];
  logic        pend [2];
  logic        pw [2];
  logic [1:0]  pbe [2];
  logic [19:0] pad [2];
  logic [15:0] pwd [2];
  int          k, free_cyc, exp_cycle, nack;
  logic        last, have_exp, exp_port, e_we;
  logic [1:0]  e_be, exp_acks, g;
  logic [19:0] e_addr;
  logic [15:0] e_wd;
  int          tie_port [4];
  int          tie_n [4];
  logic        saw_ack;

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    vt[0] = '{0, 0, 1'b1, 2'b11, 20'h00010, 16'h1234, 4, 2, 0, 1'b0, 1'b0, 16'h0000};
    vt[1] = '{0, 1, 1'b0, 2'b11, 20'h00010, 16'h0000, 4, 0, 3, 1'b0, 1'b0, 16'h1234};
    vt[2] = '{0, 0, 1'b1, 2'b01, 20'h00020, 16'hABCD, 4, 2, 0, 1'b1, 1'b0, 16'h0000};
    vt[3] = '{0, 1, 1'b0, 2'b11, 20'h00020, 16'h0000, 4, 0, 3, 1'b0, 1'b0, 16'h00CD};
    vt[4] = '{0, 1, 1'b1, 2'b10, 20'h00020, 16'h5678, 4, 2, 0, 1'b0, 1'b1, 16'h0000};
    vt[5] = '{0, 0, 1'b0, 2'b11, 20'h00020, 16'h0000, 4, 0, 3, 1'b0, 1'b0, 16'h56CD};
    vt[6] = '{1, 0, 1'b1, 2'b11, 20'h00030, 16'hBEEF, 3, 1, 0, 1'b0, 1'b0, 16'h0000};
    vt[7] = '{1, 1, 1'b0, 2'b11, 20'h00030, 16'h0000, 3, 0, 2, 1'b0, 1'b0, 16'hBEEF};
    vt[8] = '{2, 1, 1'b1, 2'b11, 20'h00040, 16'hCAFE, 6, 4, 0, 1'b0, 1'b0, 16'h0000};
    vt[9] = '{2, 0, 1'b0, 2'b11, 20'h00040, 16'h0000, 6, 0, 5, 1'b0, 1'b0, 16'hCAFE};

    rst = 3'b111;
    for (int i = 0; i < 3; i++) begin
      drive(i, 0, 1'b0, 1'b0, 2'b00, 20'h0, 16'h0);
      drive(i, 1, 1'b0, 1'b0, 2'b00, 20'h0, 16'h0);
    end
    repeat (2) @(negedge clk);
    rst = 3'b000;
    @(negedge clk);

    // Reset state
    for (int i = 0; i < 3; i++) begin
      check("reset_strobes", {ce[i], ub[i], lb[i], oe[i], we_n[i]}, 5'b11111);
      check("reset_data_oe", doe[i], 1'b0);
      check("reset_addr", a[i], 20'h0);
      check("reset_acks", {ack1[i], ack0[i]}, 2'b00);
      check("reset_rdata", rdata[i], 16'h0);
    end

    // Directed vector table
    for (int v = 0; v < 10; v++) begin
      do_access(vt[v].inst, vt[v].port, vt[v].we, vt[v].be, vt[v].addr, vt[v].wd);
      $display("vec %0d inst=%0d port=%0d we=%0b be=%b addr=%h lat=%0d rdata=%h",
               v, vt[v].inst, vt[v].port, vt[v].we, vt[v].be, vt[v].addr, o_lat, o_rd);
      check("vec_latency", o_lat, vt[v].lat);
      check("vec_ack_port", o_port, vt[v].port);
      check("vec_we_low_cycles", o_welow, vt[v].welow);
      check("vec_oe_low_cycles", o_oelow, vt[v].oelow);
      check("vec_ub", o_ub1, vt[v].ub);
      check("vec_lb", o_lb1, vt[v].lb);
      check("vec_addr", o_a1, vt[v].addr);
      if (vt[v].we) begin
        check("vec_data_out", o_dout, vt[v].wd);
        check("vec_done_data_oe", o_doe, 1'b1);
      end else begin
        check("vec_rdata", o_rd, vt[v].rd);
        check("vec_done_data_oe", o_doe, 1'b0);
      end
    end

    // Both ports held high from reset: service must alternate 0,1,0,1 every 5 cycles
    rst[0] = 1'b1;
    @(negedge clk);
    rst[0] = 1'b0;
    drive(0, 0, 1'b1, 1'b0, 2'b11, 20'h00010, 16'h0);
    drive(0, 1, 1'b1, 1'b0, 2'b11, 20'h00020, 16'h0);
    nack = 0;
    for (int n = 1; n <= 30 && nack < 4; n++) begin
      @(negedge clk);
      check("tie_ack_exclusive", ack0[0] & ack1[0], 1'b0);
      if (ack0[0] || ack1[0]) begin
        tie_port[nack] = ack1[0] ? 1 : 0;
        tie_n[nack] = n;
        $display("tie ack %0d port=%0d cycle=%0d rdata=%h", nack, tie_port[nack], n, rdata[0]);
        nack++;
      end
    end
    check("tie_ack_count", nack, 4);
    for (int i = 0; i < nack; i++) begin
      check("tie_order", tie_port[i], i % 2);
      check("tie_timing", tie_n[i], 4 + 5 * i);
    end
    drive(0, 0, 1'b0, 1'b0, 2'b00, 20'h0, 16'h0);
    drive(0, 1, 1'b0, 1'b0, 2'b00, 20'h0, 16'h0);
    repeat (6) @(negedge clk);

    // Reset during STROBE of a write aborts it silently
    drive(0, 0, 1'b1, 1'b1, 2'b11, 20'h00050, 16'h9999);
    @(negedge clk);
    @(negedge clk);
    check("abort_in_strobe_we", we_n[0], 1'b0);
    rst[0] = 1'b1;
    drive(0, 0, 1'b0, 1'b0, 2'b00, 20'h0, 16'h0);
    @(negedge clk);
    rst[0] = 1'b0;
    check("abort_ce", ce[0], 1'b1);
    check("abort_we", we_n[0], 1'b1);
    check("abort_data_oe", doe[0], 1'b0);
    check("abort_ack0", ack0[0], 1'b0);
    saw_ack = 1'b0;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      if (ack0[0] || ack1[0]) saw_ack = 1'b1;
    end
    check("abort_no_late_ack", saw_ack, 1'b0);
    $display("abort write addr=00050 acked=%0b", saw_ack);

    // Random traffic against a cycle-timeline model (WAIT_CYCLES=1 instance)
    for (int i = 0; i < 256; i++) mdl[i] = 16'h0;
    rst[0] = 1'b1;
    @(negedge clk);
    rst[0] = 1'b0;
    k = 0; free_cyc = 0; last = 1'b1; have_exp = 1'b0; exp_cycle = 0; exp_port = 1'b0;
    pend[0] = 1'b0; pend[1] = 1'b0;
    for (int c = 0; c < 800; c++) begin
      for (int p = 0; p < 2; p++) begin
        if (!pend[p] && $urandom_range(0, 2) == 0) begin
          pend[p] = 1'b1;
          pw[p]   = 1'($urandom_range(0, 1));
          pbe[p]  = 2'($urandom_range(0, 3));
          pad[p]  = 20'h00080 + 20'($urandom_range(0, 15));
          pwd[p]  = 16'($urandom);
        end
        drive(0, p, pend[p], pw[p], pbe[p], pad[p], pwd[p]);
      end
      if (k >= free_cyc && (pend[0] || pend[1])) begin
        if (pend[0] && pend[1]) g = {1'b0, ~last};
        else g = pend[1] ? 2'd1 : 2'd0;
        last = g[0]; exp_port = g[0];
        exp_cycle = k + 4; free_cyc = k + 5; have_exp = 1'b1;
        e_we = pw[g[0]]; e_be = pbe[g[0]]; e_addr = pad[g[0]]; e_wd = pwd[g[0]];
      end
      @(negedge clk);
      k++;
      exp_acks = (have_exp && k == exp_cycle) ? (exp_port ? 2'b10 : 2'b01) : 2'b00;
      check("rand_ack", {ack1[0], ack0[0]}, exp_acks);
      check("rand_oe_we_exclusive", !oe[0] && !we_n[0], 1'b0);
      if (exp_acks != 2'b00) begin
        if (e_we) begin
          if (e_be[0]) mdl[e_addr[7:0]][7:0]  = e_wd[7:0];
          if (e_be[1]) mdl[e_addr[7:0]][15:8] = e_wd[15:8];
        end else begin
          check("rand_rdata", rdata[0], mdl[e_addr[7:0]]);
        end
        $display("rand cycle=%0d port=%0d we=%0b be=%b addr=%h wdata=%h rdata=%h",
                 k, exp_port, e_we, e_be, e_addr, e_wd, rdata[0]);
        pend[exp_port] = 1'b0;
        have_exp = 1'b0;
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter WAIT_CYCLES, default 1, extra STROBE cycles per access (range 0..7).
REQ-002 SHALL have port Clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port Reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have ports req0/req1  input  1  access request from port 0 (CPU) / port 1 (loader/DMA), held until ack.
REQ-005 SHALL have ports we0/we1  input  1  1 = write, 0 = read, qualified by reqN.
REQ-006 SHALL have ports be0/be1  input  2  byte enables, active-high; [1] upper, [0] lower.
REQ-007 SHALL have ports addr0/addr1  input  20  word address.
REQ-008 SHALL have ports wdata0/wdata1  input  16  write data.
REQ-009 SHALL have ports ack0/ack1  output  1  one-cycle completion pulse.
REQ-010 SHALL have port rdata  output  16  read data, valid while ack0 or ack1 is high after a read.
REQ-011 SHALL have ports CE, UB, LB, OE, WE  output  1  SRAM strobes, active-low.
REQ-012 SHALL have port A  output  20  SRAM address.
REQ-013 SHALL have ports Data_out  output  16, Data_oe  output  1, Data_in  input  16  split SRAM data bus; Data_oe=1 drives pad.

Function
REQ-014 SHALL implement FSM states IDLE, SETUP, STROBE, DONE; IDLE->SETUP on any req, SETUP->STROBE, STROBE->DONE when wait counter is 0, DONE->IDLE unconditionally.
REQ-015 SHALL, in IDLE with a request, latch the granted port's we/be/addr/wdata and the grant index; latched values stay constant until DONE ends.
REQ-016 SHALL grant the only requester if one req is high; if both are high, grant the port not in last_grant (round-robin); last_grant updates on each grant.
REQ-017 SHALL ignore req0/req1 in SETUP, STROBE, DONE; a non-granted request waits with no loss.
REQ-018 SHALL, in IDLE: CE=UB=LB=OE=WE=1, Data_oe=0, A=0.
REQ-019 SHALL, in SETUP and STROBE: CE=0, A=latched addr, UB=~be[1], LB=~be[0]; read: OE=0, WE=1; write: OE=1, Data_oe=1, Data_out=latched wdata.
REQ-020 SHALL assert WE=0 only in STROBE cycles of a write (never in SETUP/DONE) to preserve address setup/hold.
REQ-021 SHALL load the wait counter with WAIT_CYCLES on SETUP->STROBE and decrement each STROBE cycle; STROBE lasts WAIT_CYCLES+1 cycles.
REQ-022 SHALL capture Data_in into rdata on the final STROBE cycle of a read; rdata holds until the next read capture.
REQ-023 SHALL, in DONE: CE=OE=WE=1, UB=LB=1, Data_oe held at its STROBE value (write data hold), ackN=1 for granted port only.
REQ-024 SHALL give latency: req sampled in IDLE at cycle t -> ack in cycle t+3+WAIT_CYCLES (t+4 at default).
REQ-025 SHALL treat req still high in the IDLE cycle after ack as a new request; requesters deassert req the cycle after ack.
REQ-026 SHALL never assert ack0 and ack1 in the same cycle, nor OE=0 and WE=0 together.

Reset
REQ-027 SHALL on Reset=1 at a clock edge enter IDLE, clear wait counter, latched fields and rdata to 0, set last_grant=1 (port 0 wins first tie).
REQ-028 SHALL, after reset mid-access, show all strobes at 1, Data_oe=0, ack0=ack1=0 from the next cycle; aborted access produces no ack.

Structure
REQ-029 SHALL place the state enum (IDLE, SETUP, STROBE, DONE) and port-index constants PORT_CPU=0, PORT_DMA=1 in package mem_arb_pkg.
REQ-030 SHALL factor round-robin grant selection into sub-module mem_arb_rr (inputs req0, req1, last_grant; outputs gnt_valid, gnt_idx), combinational only.
REQ-031 SHALL register all SRAM-side outputs and ack outputs (no combinational path from req to pads).

Verification
REQ-032 SHALL cover: port0 write addr=0x00010 data=0x1234 be=11 -> WE=0 for 2 cycles, ack0 at t+4, A=0x00010, Data_out=0x1234.
REQ-033 SHALL cover: port1 read addr=0x00010, SRAM model returns 0x1234 -> OE=0, WE=1 throughout, ack1 with rdata=0x1234.
REQ-034 SHALL cover: req0 and req1 high same cycle after reset -> port0 served first, port1 immediately after; next tie served port1 first.
REQ-035 SHALL cover: write be=01 -> UB=1, LB=0 in SETUP/STROBE; be=10 -> UB=0, LB=1.
REQ-036 SHALL cover: Reset pulsed during STROBE of a write -> next cycle CE=WE=1, Data_oe=0, no ack0 ever for that access.
REQ-037 SHALL cover: WAIT_CYCLES=0 and 3 -> ack at t+3 and t+6 respectively, read data still correct.
